jts16_dtack_gen: RTL and testbench

//  Parametrised 68000 DTACKn generator for multi-slave SDRAM buses. Inserts a

---
 rtl/jts16_dtack_gen.sv | 137 +++++++++++++
 tb/tb_jts16_dtack_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jts16_dtack_gen.sv
// 68000 DTACKn generator for a multi-slave SDRAM bus.
// Each bus cycle waits a fixed number of cpu_cenb ticks. It is stretched while
// any selected slave reports busy. Stall ticks past the nominal wait build up a
// debt counter. While debt is pending, later cycles are acknowledged one tick
// early, which pays the debt back.
//
// Bus contract: the CPU starts a cycle by dropping ASn. DTACKn goes low once
// the cycle may complete and stays low until the CPU releases ASn. A slave
// holds its bus_busy bit high while it is selected and its data is not yet
// valid. Only the current values of bus_cs and bus_busy are used.
module jts16_dtack_gen #(
  parameter int NCH     = 2,
  parameter int WAITS   = 2,
  parameter int DEBTW   = 4,
  parameter int RECOVER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_cen,
  input  logic             cpu_cenb,
  input  logic             ASn,
  input  logic [NCH-1:0]   bus_cs,
  input  logic [NCH-1:0]   bus_busy,
  input  logic             sdram_ok,
  output logic             DTACKn,
  output logic [DEBTW-1:0] debt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Wait counter is 3 bits wide, which covers the full 0..7 range of WAITS.
  localparam logic [2:0]       WAITS_V    = 3'(WAITS);
  localparam logic [2:0]       WAITS_M1   = (WAITS > 0) ? 3'(WAITS - 1) : 3'd0;
  localparam logic [DEBTW-1:0] DEBT_MAX   = '1;
  // With zero wait states there is nothing left to shorten.
  localparam logic             RECOVER_ON = (RECOVER != 0) && (WAITS > 0);

  state_t           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [DEBTW-1:0] debt_q, debt_d;
  logic             dtackn_q, dtackn_d;
  logic             armed_q, armed_d;
  logic             last_asn_q, last_asn_d;

  logic sel_busy;
  logic sel_any;
  logic early;
  logic at_waits;

  assign sel_busy = |(bus_cs & bus_busy);
  assign sel_any  = |bus_cs;
  assign at_waits = (wcnt_q == WAITS_V);
  // Early acknowledge is allowed one tick before the nominal point while debt is owed.
  assign early    = RECOVER_ON && (debt_q != '0) && (wcnt_q == WAITS_M1) && armed_q;

  // Next-state logic for the bus-cycle FSM, the wait counter and the debt counter.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    debt_d     = debt_q;
    dtackn_d   = dtackn_q;
    armed_d    = armed_q | sdram_ok;
    last_asn_d = ASn;

    if (ASn) begin
      // Strobe released: end of cycle, whatever state we were in.
      state_d  = ST_IDLE;
      dtackn_d = 1'b1;
      wcnt_d   = 3'd0;
    end else if (last_asn_q) begin
      // A new cycle begins. An old acknowledge must never leak into it.
      state_d  = ST_WAIT;
      dtackn_d = 1'b1;
      wcnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dtackn_d = 1'b1;
        end
        ST_WAIT: begin
          if (cpu_cenb && !at_waits) begin
            wcnt_d = wcnt_q + 3'd1;
          end
          if (!sel_any) begin
            // Access that does not use the bus: acknowledge at once.
            state_d  = ST_ACK;
            dtackn_d = 1'b0;
          end else if (!sel_busy && (at_waits || early)) begin
            state_d  = ST_ACK;
            dtackn_d = 1'b0;
            if (early) begin
              debt_d = debt_q - 1'b1;
            end
          end
          // Each CPU tick spent stalled beyond the nominal wait adds to the debt.
          if (at_waits && sel_busy && cpu_cen && armed_q && (debt_q != DEBT_MAX)) begin
            debt_d = debt_q + 1'b1;
          end
        end
        ST_ACK: begin
          dtackn_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          dtackn_d = 1'b1;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 3'd0;
      debt_q     <= '0;
      dtackn_q   <= 1'b1;
      armed_q    <= 1'b0;
      last_asn_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      debt_q     <= debt_d;
      dtackn_q   <= dtackn_d;
      armed_q    <= armed_d;
      last_asn_q <= last_asn_d;
    end
  end

  assign DTACKn = dtackn_q;
  assign debt   = debt_q;

endmodule

// File: tb/tb_jts16_dtack_gen.sv
// Bench for jts16_dtack_gen. Four configurations share one stimulus stream:
//   u0 WAITS=2 DEBTW=4 RECOVER=1
//   u1 WAITS=2 DEBTW=2 RECOVER=1 (saturation)
//   u2 WAITS=2 DEBTW=4 RECOVER=0
//   u3 WAITS=0 DEBTW=4 RECOVER=1
// Each bus cycle's stimulus is planned in advance as per-clock arrays. A
// timeline model then predicts the acknowledge clock and the final debt.
module tb_jts16_dtack_gen;

  localparam int NDUT = 4;
  localparam int TL   = 64;
  localparam int P_W   [NDUT] = '{2, 2, 2, 0};
  localparam int P_MAX [NDUT] = '{15, 3, 15, 15};
  localparam int P_REC [NDUT] = '{1, 1, 0, 1};

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_cen = 1'b0;
  logic       cpu_cenb = 1'b0;
  logic       asn = 1'b1;
  logic [1:0] bus_cs = 2'b00;
  logic [1:0] bus_busy = 2'b00;
  logic       sdram_ok = 1'b0;

  logic       dt0, dt1, dt2, dt3;
  logic [3:0] debt0, debt2, debt3;
  logic [1:0] debt1;

  always #5 clk = ~clk;

  jts16_dtack_gen #(.NCH(2), .WAITS(2), .DEBTW(4), .RECOVER(1)) u0 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(asn),
    .bus_cs(bus_cs), .bus_busy(bus_busy), .sdram_ok(sdram_ok),
    .DTACKn(dt0), .debt(debt0));
  jts16_dtack_gen #(.NCH(2), .WAITS(2), .DEBTW(2), .RECOVER(1)) u1 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(asn),
    .bus_cs(bus_cs), .bus_busy(bus_busy), .sdram_ok(sdram_ok),
    .DTACKn(dt1), .debt(debt1));
  jts16_dtack_gen #(.NCH(2), .WAITS(2), .DEBTW(4), .RECOVER(0)) u2 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(asn),
    .bus_cs(bus_cs), .bus_busy(bus_busy), .sdram_ok(sdram_ok),
    .DTACKn(dt2), .debt(debt2));
  jts16_dtack_gen #(.NCH(2), .WAITS(0), .DEBTW(4), .RECOVER(1)) u3 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(asn),
    .bus_cs(bus_cs), .bus_busy(bus_busy), .sdram_ok(sdram_ok),
    .DTACKn(dt3), .debt(debt3));

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int m_debt [NDUT];
  bit m_armed;
  int obs_ack [NDUT];

  bit         cen_a  [TL];
  bit         cenb_a [TL];
  logic [1:0] busy_a [TL];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_dt(input int k);
    case (k)
      0: return int'(dt0);
      1: return int'(dt1);
      2: return int'(dt2);
      default: return int'(dt3);
    endcase
  endfunction

  function automatic int get_debt(input int k);
    case (k)
      0: return int'(debt0);
      1: return int'(debt1);
      2: return int'(debt2);
      default: return int'(debt3);
    endcase
  endfunction

  // Timeline model. Clock 0 is the one that sees ASn fall. wcnt at clock t is
  // the number of cenb ticks seen on clocks 1..t-1, capped at WAITS.
  function automatic void model_cycle(input int k, input logic [1:0] cs,
                                      output int ack, output int dout);
    int w;
    int d;
    w   = 0;
    d   = m_debt[k];
    ack = -1;
    for (int t = 1; t < TL; t++) begin
      bit sb;
      bit early;
      sb = |(cs & busy_a[t]);
      if (cs == 2'b00) begin
        ack = t;
        break;
      end
      early = (P_REC[k] != 0) && (P_W[k] > 0) && (d != 0) && (w == P_W[k] - 1) && m_armed;
      if (!sb && (w == P_W[k] || early)) begin
        ack = t;
        if (early) d = d - 1;
        break;
      end
      if (w == P_W[k] && sb && cen_a[t] && m_armed && d < P_MAX[k]) d = d + 1;
      if (cenb_a[t] && w < P_W[k]) w = w + 1;
    end
    dout = d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Regular tick pattern: cenb on odd clocks, cen on even clocks; busy on clocks 1..busy_last.
  task automatic gen_directed(input int busy_last, input logic [1:0] busy_val);
    for (int t = 0; t < TL; t++) begin
      cenb_a[t] = (t % 2) == 1;
      cen_a[t]  = (t > 0) && ((t % 2) == 0);
      busy_a[t] = (t >= 1 && t <= busy_last) ? busy_val : 2'b00;
    end
  endtask

  // Random ticks and per-channel busy. Busy ends by clock 16 and cenb is forced
  // from clock 30 on, so every cycle is acknowledged well inside the array.
  task automatic gen_random();
    int busy_end;
    busy_end = $urandom_range(0, 16);
    for (int t = 0; t < TL; t++) begin
      cen_a[t]  = 1'($urandom_range(0, 1));
      cenb_a[t] = (t >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
      busy_a[t] = (t >= 1 && t <= busy_end) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
  endtask

  task automatic idle(input int n, input bit ok);
    for (int i = 0; i < n; i++) begin
      asn      = 1'b1;
      sdram_ok = ok;
      bus_cs   = 2'($urandom_range(0, 3));
      bus_busy = 2'($urandom_range(0, 3));
      cpu_cen  = 1'($urandom_range(0, 1));
      cpu_cenb = 1'($urandom_range(0, 1));
      step();
      if (ok) m_armed = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
        check_eq($sformatf("idle_dtack%0d", k), get_dt(k), 1);
        check_eq($sformatf("idle_debt%0d", k), get_debt(k), m_debt[k]);
      end
    end
    sdram_ok = 1'b0;
  endtask

  task automatic reset_all();
    rst      = 1'b1;
    asn      = 1'b0;
    step();
    rst      = 1'b0;
    asn      = 1'b1;
    m_armed  = 1'b0;
    for (int k = 0; k < NDUT; k++) m_debt[k] = 0;
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("rst_dtack%0d", k), get_dt(k), 1);
      check_eq($sformatf("rst_debt%0d", k), get_debt(k), 0);
    end
  endtask

  // One bus cycle using the planned arrays. With do_rst set, reset is applied
  // while the cycle is still acknowledged instead of releasing ASn.
  task automatic run_cycle(input logic [1:0] cs, input int extra, input bit do_rst);
    int ack [NDUT];
    int dn  [NDUT];
    int tend;
    tend = 0;
    for (int k = 0; k < NDUT; k++) begin
      model_cycle(k, cs, ack[k], dn[k]);
      if (ack[k] < 0) ack[k] = TL - 8;
      if (ack[k] > tend) tend = ack[k];
      obs_ack[k] = -1;
    end
    tend = tend + extra;
    if (tend > TL - 1) tend = TL - 1;

    asn      = 1'b0;
    bus_cs   = cs;
    cpu_cen  = cen_a[0];
    cpu_cenb = cenb_a[0];
    bus_busy = busy_a[0];
    step();
    for (int k = 0; k < NDUT; k++) check_eq($sformatf("edge_dtack%0d", k), get_dt(k), 1);

    for (int t = 1; t <= tend; t++) begin
      cpu_cen  = cen_a[t];
      cpu_cenb = cenb_a[t];
      bus_busy = busy_a[t];
      step();
      for (int k = 0; k < NDUT; k++) begin
        check_eq($sformatf("dtack%0d_t%0d", k, t), get_dt(k), (t >= ack[k]) ? 0 : 1);
        if (get_dt(k) == 0 && obs_ack[k] < 0) obs_ack[k] = t;
      end
    end

    if (do_rst) begin
      for (int k = 0; k < NDUT; k++) check_eq($sformatf("prerst_debt%0d", k), get_debt(k), dn[k]);
      check_eq("prerst_dtack0", get_dt(0), 0);
      check_eq("prerst_debt0_is2", get_debt(0), 2);
      reset_all();
      step();
      for (int k = 0; k < NDUT; k++) begin
        check_eq($sformatf("postrst_dtack%0d", k), get_dt(k), 1);
        check_eq($sformatf("postrst_debt%0d", k), get_debt(k), 0);
      end
    end else begin
      asn      = 1'b1;
      bus_busy = 2'b00;
      cpu_cen  = 1'b0;
      cpu_cenb = 1'b0;
      step();
      for (int k = 0; k < NDUT; k++) begin
        check_eq($sformatf("release_dtack%0d", k), get_dt(k), 1);
        check_eq($sformatf("end_debt%0d", k), get_debt(k), dn[k]);
        m_debt[k] = dn[k];
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < NDUT; k++) m_debt[k] = 0;
    m_armed = 1'b0;
    step();
    reset_all();
    idle(2, 1'b0);

    // Plain bus access: ack one clock after the 2nd cenb tick.
    gen_directed(0, 2'b00);
    run_cycle(2'b01, 2, 1'b0);
    check_eq("t1_ack0", obs_ack[0], 4);
    check_eq("t1_ack_w0", obs_ack[3], 1);
    idle(1, 1'b0);

    // Non-bus access: immediate ack, no debt.
    gen_directed(0, 2'b00);
    run_cycle(2'b00, 1, 1'b0);
    for (int k = 0; k < NDUT; k++) check_eq($sformatf("t2_ack%0d", k), obs_ack[k], 1);
    idle(1, 1'b0);

    // Stall while not armed: debt must stay at zero.
    gen_directed(8, 2'b10);
    run_cycle(2'b10, 1, 1'b0);
    check_eq("t4_unarmed_debt0", get_debt(0), 0);
    check_eq("t4_unarmed_ack0", obs_ack[0], 9);

    // Arm, then stall three cen ticks past the nominal wait.
    idle(1, 1'b1);
    idle(1, 1'b0);
    gen_directed(8, 2'b11);
    run_cycle(2'b10, 1, 1'b0);
    check_eq("t3_debt0", get_debt(0), 3);
    check_eq("t3_debt_w0", get_debt(3), 4);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      gen_directed(0, 2'b00);
      run_cycle(2'b10, 1, 1'b0);
      check_eq($sformatf("t3_early_ack0_%0d", i), obs_ack[0], 2);
      check_eq($sformatf("t3_recover_debt0_%0d", i), get_debt(0), 2 - i);
      check_eq($sformatf("t6_norec_ack2_%0d", i), obs_ack[2], 4);
    end
    check_eq("t6_norec_debt2", get_debt(2), 3);

    // Six-tick stall: the 2-bit counter saturates at 3.
    idle(1, 1'b0);
    gen_directed(14, 2'b10);
    run_cycle(2'b10, 1, 1'b0);
    check_eq("t5_sat_debt1", get_debt(1), 3);
    check_eq("t5_debt0", get_debt(0), 6);

    // Pay back to 3, then reset during an acknowledged cycle that leaves debt at 2.
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      gen_directed(0, 2'b00);
      run_cycle(2'b01, 0, 1'b0);
    end
    check_eq("t6_debt0_before", get_debt(0), 3);
    idle(1, 1'b0);
    gen_directed(0, 2'b00);
    run_cycle(2'b01, 2, 1'b1);

    // Randomized traffic: re-arm, then mixed bus/non-bus cycles.
    idle(2, 1'b1);
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(1, 3), 1'b0);
      gen_random();
      run_cycle(2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
